// File: rtl/conv_window_gen.sv
// KxK sliding-window generator for a raster pixel stream. K-1 unreset line delays feed a
// window register array; only windows lying fully inside the image are flagged valid.
module conv_window_gen #(
    parameter int BIT_WIDTH = 8,
    parameter int IMG_W     = 32,
    parameter int IMG_H     = 32,
    parameter int K         = 5,
    localparam int RW       = (IMG_H > 1) ? $clog2(IMG_H) : 1,
    localparam int CW       = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [BIT_WIDTH-1:0]       pix_in,
    input  logic                       in_valid,
    output logic [K*K*BIT_WIDTH-1:0]   win_out,
    output logic                       out_valid,
    output logic [RW-1:0]              out_row,
    output logic [CW-1:0]              out_col,
    output logic                       frame_done
);

    typedef enum logic [0:0] {
        FILL   = 1'b0,
        STREAM = 1'b1
    } state_e;

    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_KM1  = RW'(K - 1);
    localparam logic [RW-1:0] ROW_KM2  = RW'(K - 2);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_KM1  = CW'(K - 1);

    logic [BIT_WIDTH-1:0] ld_q      [K-1][IMG_W];
    logic [BIT_WIDTH-1:0] ld_d      [K-1][IMG_W];
    logic [BIT_WIDTH-1:0] col_new_s [K];
    logic [BIT_WIDTH-1:0] win_q     [K][K];
    logic [BIT_WIDTH-1:0] win_d     [K][K];

    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] out_row_q, out_row_d;
    logic [CW-1:0] out_col_q, out_col_d;
    logic          out_valid_q, out_valid_d;
    logic          frame_done_q, frame_done_d;
    state_e        state_q, state_d;
    logic          col_last_s;
    logic          row_last_s;

    // New window column: row r comes from line delay K-1-r, the bottom row is the live pixel.
    always_comb begin
        for (int r = 0; r < K - 1; r++) begin
            col_new_s[r] = ld_q[K-2-r][IMG_W-1];
        end
        col_new_s[K-1] = pix_in;
    end

    // Line-delay chain: each delay is IMG_W deep and feeds the next one.
    always_comb begin
        ld_d = ld_q;
        if (in_valid) begin
            for (int j = 0; j < K - 1; j++) begin
                for (int i = 1; i < IMG_W; i++) begin
                    ld_d[j][i] = ld_q[j][i-1];
                end
            end
            ld_d[0][0] = pix_in;
            for (int j = 1; j < K - 1; j++) begin
                ld_d[j][0] = ld_q[j-1][IMG_W-1];
            end
        end else begin
            ld_d = ld_q;
        end
    end

    // Line-delay storage carries no reset; stale contents are masked by FILL gating.
    always_ff @(posedge clk) begin
        ld_q <= ld_d;
    end

    assign col_last_s = (col_q == COL_LAST);
    assign row_last_s = (row_q == ROW_LAST);

    // Next-state logic for counters, FSM, window and registered outputs.
    always_comb begin
        row_d        = row_q;
        col_d        = col_q;
        state_d      = state_q;
        win_d        = win_q;
        out_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        out_row_d    = out_row_q;
        out_col_d    = out_col_q;
        if (in_valid) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
                win_d[r][K-1] = col_new_s[r];
            end
            out_valid_d = (state_q == STREAM) && (row_q >= ROW_KM1) && (col_q >= COL_KM1);
            out_row_d   = row_q - ROW_KM1;
            out_col_d   = col_q - COL_KM1;
            if (col_last_s) begin
                col_d = {CW{1'b0}};
                if (row_last_s) begin
                    row_d        = {RW{1'b0}};
                    frame_done_d = 1'b1;
                end else begin
                    row_d = row_q + RW'(1);
                end
            end else begin
                col_d = col_q + CW'(1);
            end
            case (state_q)
                FILL: begin
                    if ((row_q == ROW_KM2) && col_last_s) begin
                        state_d = STREAM;
                    end else begin
                        state_d = FILL;
                    end
                end
                STREAM: begin
                    if (row_last_s && col_last_s) begin
                        state_d = FILL;
                    end else begin
                        state_d = STREAM;
                    end
                end
                default: state_d = FILL;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Control, window and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_q        <= {RW{1'b0}};
            col_q        <= {CW{1'b0}};
            state_q      <= FILL;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            out_row_q    <= {RW{1'b0}};
            out_col_q    <= {CW{1'b0}};
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    win_q[r][c] <= {BIT_WIDTH{1'b0}};
                end
            end
        end else begin
            row_q        <= row_d;
            col_q        <= col_d;
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
            out_row_q    <= out_row_d;
            out_col_q    <= out_col_d;
            win_q        <= win_d;
        end
    end

    for (genvar gr = 0; gr < K; gr++) begin : g_row
        for (genvar gc = 0; gc < K; gc++) begin : g_col
            assign win_out[(gr*K+gc)*BIT_WIDTH +: BIT_WIDTH] = win_q[gr][gc];
        end
    end

    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;
    assign out_row    = out_row_q;
    assign out_col    = out_col_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen: a small K=3 5x4 instance plus a default-size instance.
module tb_conv_window_gen;

    localparam int K  = 3;
    localparam int W  = 5;
    localparam int H  = 4;
    localparam int BW = 8;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [BW-1:0]       pix_in = 8'd0;
    logic                in_valid = 1'b0;
    logic [K*K*BW-1:0]   win_out;
    logic                out_valid;
    logic [1:0]          out_row;
    logic [2:0]          out_col;
    logic                frame_done;

    logic [7:0]          b_pix = 8'd0;
    logic                b_valid = 1'b0;
    logic [25*8-1:0]     b_win;
    logic                b_ov;
    logic [4:0]          b_row;
    logic [4:0]          b_col;
    logic                b_fd;

    typedef struct packed {
        logic [K*K*BW-1:0] win;
        logic [1:0]        row;
        logic [2:0]        col;
        logic              fd;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   pulses = 0;

    always #5 clk = ~clk;

    conv_window_gen #(.BIT_WIDTH(BW), .IMG_W(W), .IMG_H(H), .K(K)) dut (
        .clk(clk), .rst(rst), .pix_in(pix_in), .in_valid(in_valid),
        .win_out(win_out), .out_valid(out_valid), .out_row(out_row),
        .out_col(out_col), .frame_done(frame_done)
    );

    conv_window_gen dut_big (
        .clk(clk), .rst(rst), .pix_in(b_pix), .in_valid(b_valid),
        .win_out(b_win), .out_valid(b_ov), .out_row(b_row),
        .out_col(b_col), .frame_done(b_fd)
    );

    function automatic logic [K*K*BW-1:0] exp_win(input int base, input int r0, input int c0);
        logic [K*K*BW-1:0] w;
        w = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                w[(r*K+c)*BW +: BW] = 8'(base + (r0 + r) * W + c0 + c);
            end
        end
        return w;
    endfunction

    task automatic send_pix(input int base, input int r, input int c);
        exp_t e;
        @(negedge clk);
        pix_in   = 8'(base + r * W + c);
        in_valid = 1'b1;
        if (r >= K - 1 && c >= K - 1) begin
            e.win = exp_win(base, r - K + 1, c - K + 1);
            e.row = 2'(r - K + 1);
            e.col = 3'(c - K + 1);
            e.fd  = (r == H - 1) && (c == W - 1);
            sb_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            pix_in   = 8'hEE;
        end
    endtask

    task automatic send_frame(input int base, input bit gaps);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (gaps) begin
                    for (int g = 0; g < 3 && $urandom_range(1, 0) == 1; g++) idle(1);
                end
                send_pix(base, r, c);
            end
        end
    endtask

    // Pops the scoreboard on every window pulse of the small instance.
    task automatic monitor_small();
        exp_t e;
        logic prev_v;
        forever begin
            @(posedge clk);
            prev_v = in_valid;
            #1;
            if (out_valid === 1'b1) begin
                pulses++;
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_window row=%0d col=%0d win=%h", out_row, out_col, win_out);
                end else begin
                    e = sb_q.pop_front();
                    if ({win_out, out_row, out_col, frame_done} !== e) begin
                        errors++;
                        $display("FAIL sb_window got win=%h row=%0d col=%0d fd=%b exp win=%h row=%0d col=%0d fd=%b",
                                 win_out, out_row, out_col, frame_done, e.win, e.row, e.col, e.fd);
                    end
                end
                checks++;
                if (prev_v !== 1'b1) begin
                    errors++;
                    $display("FAIL valid_after_gap got out_valid=1 exp 0");
                end
                checks++;
                if (out_col > 3'd2) begin
                    errors++;
                    $display("FAIL col_range got out_col=%0d exp <=2", out_col);
                end
            end else if (frame_done === 1'b1) begin
                checks++;
                errors++;
                $display("FAIL frame_done_alone got frame_done=1 out_valid=%b exp out_valid=1", out_valid);
            end
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({out_valid, frame_done, out_row, out_col} !== 7'd0) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 0", {out_valid, frame_done, out_row, out_col});
        end
        checks++;
        if (win_out !== '0) begin
            errors++;
            $display("FAIL reset_win got %h exp 0", win_out);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic end_frame_checks(input string name, input int exp_pulses);
        idle(3);
        checks++;
        if (pulses != exp_pulses) begin
            errors++;
            $display("FAIL %s_pulses got %0d exp %0d", name, pulses, exp_pulses);
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing got %0d pending exp 0", name, sb_q.size());
        end
    endtask

    task automatic test_continuous();
        pulses = 0;
        send_frame(0, 1'b0);
        end_frame_checks("continuous", 6);
    endtask

    task automatic test_idle_hold();
        idle(4);
        checks++;
        if (win_out !== exp_win(0, 1, 2)) begin
            errors++;
            $display("FAIL idle_hold_win got %h exp %h", win_out, exp_win(0, 1, 2));
        end
        checks++;
        if ({out_valid, frame_done, out_row, out_col} !== {1'b0, 1'b0, 2'd1, 3'd2}) begin
            errors++;
            $display("FAIL idle_hold_ctrl got %b exp %b", {out_valid, frame_done, out_row, out_col},
                     {1'b0, 1'b0, 2'd1, 3'd2});
        end
    endtask

    task automatic test_gaps();
        pulses = 0;
        send_frame(0, 1'b1);
        end_frame_checks("gaps", 6);
    endtask

    task automatic test_back_to_back();
        pulses = 0;
        send_frame(0, 1'b0);
        send_frame(100, 1'b0);
        end_frame_checks("back_to_back", 12);
    endtask

    task automatic test_reset_mid();
        pulses = 0;
        for (int p = 0; p < 10; p++) send_pix(0, p / W, p % W);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if ({out_valid, frame_done, out_row, out_col} !== 7'd0 || win_out !== '0) begin
            errors++;
            $display("FAIL reset_mid got ctrl=%b win=%h exp 0", {out_valid, frame_done, out_row, out_col}, win_out);
        end
        @(negedge clk);
        rst = 1'b1;
        send_frame(0, 1'b0);
        end_frame_checks("reset_mid", 6);
    endtask

    task automatic test_default_config();
        int   n_win;
        int   er;
        int   ec;
        logic [25*8-1:0] ew;
        n_win = 0;
        for (int n = 0; n < 1024; n++) begin
            @(negedge clk);
            b_pix   = 8'(n);
            b_valid = 1'b1;
            @(posedge clk);
            #1;
            if (b_ov === 1'b1) begin
                er = n_win / 28;
                ec = n_win % 28;
                for (int r = 0; r < 5; r++) begin
                    for (int c = 0; c < 5; c++) begin
                        ew[(r*5+c)*8 +: 8] = 8'((er + r) * 32 + ec + c);
                    end
                end
                checks++;
                if (b_win !== ew || b_row !== 5'(er) || b_col !== 5'(ec) || b_fd !== (n_win == 783)) begin
                    errors++;
                    $display("FAIL big_window got row=%0d col=%0d fd=%b win=%h exp row=%0d col=%0d fd=%b win=%h",
                             b_row, b_col, b_fd, b_win, er, ec, (n_win == 783), ew);
                end
                n_win++;
                if (n == 1023) begin
                    checks++;
                    if (b_row !== 5'd27 || b_col !== 5'd27 || b_win[24*8 +: 8] !== 8'hFF || b_fd !== 1'b1) begin
                        errors++;
                        $display("FAIL big_last got row=%0d col=%0d e44=%h fd=%b exp 27 27 ff 1",
                                 b_row, b_col, b_win[24*8 +: 8], b_fd);
                    end
                end
            end else if (b_fd === 1'b1) begin
                checks++;
                errors++;
                $display("FAIL big_frame_done_alone got frame_done=1 exp 0");
            end
        end
        @(negedge clk);
        b_valid = 1'b0;
        checks++;
        if (n_win != 784) begin
            errors++;
            $display("FAIL big_pulses got %0d exp 784", n_win);
        end
    endtask

    initial begin
        fork
            monitor_small();
        join_none
        test_reset();
        test_continuous();
        test_idle_hold();
        test_gaps();
        test_back_to_back();
        test_reset_mid();
        test_default_config();
        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
